// File: rtl/dterm_if.sv
// ---------------------------------------------------------------------------
// dterm_if
//   Bundles the sample/coefficient inputs and the registered derivative-term
//   outputs of dterm_pipe.
//   master : drives err_sat, err_vld, d_coeff, clr; observes D_term, D_vld, primed
//   slave  : the dterm_pipe side (inverse directions)
//   Signals
//     err_sat  signed ERR_W    saturated error sample
//     err_vld  1               err_sat valid this cycle
//     d_coeff  signed COEFF_W  derivative gain, consumed one cycle after err_vld
//     clr      1               synchronous flush of history and pipeline
//     D_term   signed OUT_W    registered derivative term
//     D_vld    1               D_term updated this cycle
//     primed   1               history holds DEPTH samples
// ---------------------------------------------------------------------------
interface dterm_if #(
  parameter int ERR_W   = 10,
  parameter int SAT_W   = 8,
  parameter int COEFF_W = 5
);
  localparam int OUT_W = SAT_W + COEFF_W;

  logic signed [ERR_W-1:0]   err_sat;
  logic                      err_vld;
  logic signed [COEFF_W-1:0] d_coeff;
  logic                      clr;
  logic signed [OUT_W-1:0]   D_term;
  logic                      D_vld;
  logic                      primed;

  modport master (
    output err_sat, err_vld, d_coeff, clr,
    input  D_term, D_vld, primed
  );

  modport slave (
    input  err_sat, err_vld, d_coeff, clr,
    output D_term, D_vld, primed
  );
endinterface

// File: rtl/dterm_pipe.sv
// ---------------------------------------------------------------------------
// dterm_pipe
//   Derivative-term engine for the PID controller. Keeps a DEPTH-deep history
//   of error samples, differences each new sample against the oldest one,
//   saturates the difference to SAT_W bits, multiplies it by the runtime gain
//   d_coeff and presents a registered, valid-qualified D_term.
//
//   Ports
//     clk   in  system clock, everything on posedge
//     rst   in  synchronous active-high reset (beats clr)
//     bus   slave modport of dterm_if:
//             err_sat/err_vld in  - sample stream
//             d_coeff         in  - gain, used in stage 2
//             clr             in  - flush history and pipeline
//             D_term/D_vld    out - result and one-cycle update pulse
//             primed          out - history full, differences are real
//
//   Optional feature: define DTERM_LPF_EN to add a third stage, a 1-pole
//   smoother y <= (y + p) >>> 1 on each product; latency becomes 3 clocks.
//   Without it D_term is the raw product and latency is 2 clocks.
// ---------------------------------------------------------------------------
module dterm_pipe #(
  parameter int ERR_W   = 10,
  parameter int SAT_W   = 8,
  parameter int COEFF_W = 5,
  parameter int DEPTH   = 2
) (
  input  logic    clk,
  input  logic    rst,
  dterm_if.slave  bus
);
  localparam int OUT_W  = SAT_W + COEFF_W;
  localparam int FILL_W = $clog2(DEPTH + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(DEPTH);

  // Clamp an ERR_W+1 bit difference into the signed SAT_W range.
  function automatic logic signed [SAT_W-1:0] sat_fn(input logic signed [ERR_W:0] d);
    logic signed [SAT_W-1:0] r;
    if (int'(d) > (2 ** (SAT_W - 1)) - 1)
      r = {1'b0, {(SAT_W-1){1'b1}}};
    else if (int'(d) < -(2 ** (SAT_W - 1)))
      r = {1'b1, {(SAT_W-1){1'b0}}};
    else
      r = SAT_W'(d);
    return r;
  endfunction

  // Full-precision signed product; OUT_W bits hold any SAT_W x COEFF_W result.
  function automatic logic signed [OUT_W-1:0] mul_fn(input logic signed [SAT_W-1:0] a,
                                                     input logic signed [COEFF_W-1:0] b);
    logic signed [OUT_W-1:0] ae;
    logic signed [OUT_W-1:0] be;
    ae = OUT_W'(a);
    be = OUT_W'(b);
    return ae * be;
  endfunction

  // History, fill counter and stage registers
  logic signed [ERR_W-1:0] hist_q [DEPTH];
  logic signed [ERR_W-1:0] hist_d [DEPTH];
  logic [FILL_W-1:0]       fill_q, fill_d;
  logic                    primed_w;

  logic signed [ERR_W:0]   diff_raw;
  logic signed [ERR_W:0]   diff_gated;

  logic signed [SAT_W-1:0] sat_diff_p1_q, sat_diff_p1_d;
  logic                    vld_p1_q, vld_p1_d;

  logic signed [OUT_W-1:0] prod_p2_q, prod_p2_d;
  logic                    vld_p2_q, vld_p2_d;

  assign primed_w = (fill_q == FILL_FULL);

  // ---- stage 1: history shift, difference against oldest, saturate ----
  always_comb begin
    // Extend both operands one bit so the subtraction cannot overflow.
    diff_raw   = {bus.err_sat[ERR_W-1], bus.err_sat} -
                 {hist_q[DEPTH-1][ERR_W-1], hist_q[DEPTH-1]};
    // Until the history is full the oldest entry is not a real sample.
    diff_gated = primed_w ? diff_raw : '0;

    hist_d        = hist_q;
    fill_d        = fill_q;
    sat_diff_p1_d = sat_diff_p1_q;
    vld_p1_d      = 1'b0;

    if (bus.clr) begin
      // A coincident sample is discarded along with the history.
      for (int i = 0; i < DEPTH; i++) hist_d[i] = '0;
      fill_d        = '0;
      sat_diff_p1_d = '0;
    end else if (bus.err_vld) begin
      for (int i = DEPTH - 1; i > 0; i--) hist_d[i] = hist_q[i-1];
      hist_d[0]     = bus.err_sat;
      fill_d        = primed_w ? fill_q : fill_q + 1'b1;
      sat_diff_p1_d = sat_fn(diff_gated);
      vld_p1_d      = 1'b1;
    end
  end

  // ---- stage 2: gain multiply ----
  always_comb begin
    prod_p2_d = prod_p2_q;
    vld_p2_d  = 1'b0;
    if (bus.clr) begin
      prod_p2_d = '0;
    end else if (vld_p1_q) begin
      prod_p2_d = mul_fn(sat_diff_p1_q, bus.d_coeff);
      vld_p2_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) hist_q[i] <= '0;
      fill_q        <= '0;
      sat_diff_p1_q <= '0;
      vld_p1_q      <= 1'b0;
      prod_p2_q     <= '0;
      vld_p2_q      <= 1'b0;
    end else begin
      hist_q        <= hist_d;
      fill_q        <= fill_d;
      sat_diff_p1_q <= sat_diff_p1_d;
      vld_p1_q      <= vld_p1_d;
      prod_p2_q     <= prod_p2_d;
      vld_p2_q      <= vld_p2_d;
    end
  end

`ifdef DTERM_LPF_EN
  // Average of previous output and new product; the OUT_W+1 bit sum keeps
  // the carry so the halving is exact before dropping back to OUT_W bits.
  function automatic logic signed [OUT_W-1:0] lpf_fn(input logic signed [OUT_W-1:0] y,
                                                     input logic signed [OUT_W-1:0] p);
    logic signed [OUT_W:0] s;
    s = {y[OUT_W-1], y} + {p[OUT_W-1], p};
    return s[OUT_W:1];
  endfunction

  logic signed [OUT_W-1:0] y_p3_q, y_p3_d;
  logic                    vld_p3_q, vld_p3_d;

  // ---- stage 3: 1-pole smoother ----
  always_comb begin
    y_p3_d   = y_p3_q;
    vld_p3_d = 1'b0;
    if (bus.clr) begin
      y_p3_d = '0;
    end else if (vld_p2_q) begin
      y_p3_d   = lpf_fn(y_p3_q, prod_p2_q);
      vld_p3_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_p3_q   <= '0;
      vld_p3_q <= 1'b0;
    end else begin
      y_p3_q   <= y_p3_d;
      vld_p3_q <= vld_p3_d;
    end
  end

  assign bus.D_term = y_p3_q;
  assign bus.D_vld  = vld_p3_q;
`else
  assign bus.D_term = prod_p2_q;
  assign bus.D_vld  = vld_p2_q;
`endif

  assign bus.primed = primed_w;

endmodule
